// File: rtl/ppfifo_pattern_source.sv
// ppfifo_pattern_source: user-side test data source for a ping-pong FIFO write port.
// Each run writes write_count words in one of four patterns (INC, LFSR, WALK1, CONST),
// split into bursts no larger than the granted channel's capacity.
//
// Handshake: a channel is requested only while activate==0 and its ready bit is set.
// Activate is granted one-hot on the lowest ready channel. One strobe per cycle follows,
// starting the cycle after activate rises. Activate drops the cycle after the last strobe.
// Strobe is never high while activate is zero.
module ppfifo_pattern_source #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    CHANNELS    = 2,
  parameter int                    COUNT_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS   = DATA_WIDTH'(32'h80200003)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [DATA_WIDTH-1:0]  seed,
  input  logic [COUNT_WIDTH-1:0] write_count,
  output logic                   busy,
  output logic                   finished,
  output logic [COUNT_WIDTH-1:0] words_written,
  input  logic [CHANNELS-1:0]    ready,
  output logic [CHANNELS-1:0]    activate,
  input  logic [COUNT_WIDTH-1:0] fifo_size,
  output logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   strobe,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_WRITE    = 3'd2,
    S_RELEASE  = 3'd3,
    S_FINISHED = 3'd4
  } state_t;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_WALK1 = 2'd2;

  state_t                 state;
  logic [1:0]             mode_q;
  logic [DATA_WIDTH-1:0]  pat;        // word to emit on the next strobe
  logic [COUNT_WIDTH-1:0] remaining;  // words still to write in this run
  logic [COUNT_WIDTH-1:0] burst;      // words in the current buffer
  logic [COUNT_WIDTH-1:0] burst_cnt;  // strobes issued in the current buffer

  logic [CHANNELS-1:0]    lowest_ready;
  logic [COUNT_WIDTH-1:0] burst_calc;
  logic [DATA_WIDTH-1:0]  walk_shift;
  logic [DATA_WIDTH-1:0]  start_word;
  logic [DATA_WIDTH-1:0]  next_word;

  assign state_dbg = state;

  // Grant selection and burst sizing: isolate the lowest set ready bit; burst = min(size, remaining)
  always_comb begin
    lowest_ready = ready & (~ready + CHANNELS'(1));
    burst_calc   = (fifo_size < remaining) ? fifo_size : remaining;
  end

  // First word of a run, derived from the live mode/seed inputs at start
  always_comb begin
    walk_shift = DATA_WIDTH'(seed % DATA_WIDTH);
    case (mode)
      MODE_INC:   start_word = seed;
      MODE_LFSR:  start_word = (seed == '0) ? '1 : seed;  // an all-zero LFSR would lock up
      MODE_WALK1: start_word = DATA_WIDTH'(1) << walk_shift;
      default:    start_word = seed;
    endcase
  end

  // Successor of the current pattern word, following the mode latched at start
  always_comb begin
    case (mode_q)
      MODE_INC:   next_word = pat + DATA_WIDTH'(1);
      MODE_LFSR:  next_word = (pat >> 1) ^ (pat[0] ? LFSR_TAPS : '0);
      MODE_WALK1: next_word = {pat[DATA_WIDTH-2:0], pat[DATA_WIDTH-1]};
      default:    next_word = pat;
    endcase
  end

  // Run controller: start, grant, burst write, release, finish, and abort on enable drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      finished      <= 1'b0;
      words_written <= '0;
      activate      <= '0;
      strobe        <= 1'b0;
      fifo_data     <= '0;
      mode_q        <= '0;
      pat           <= '0;
      remaining     <= '0;
      burst         <= '0;
      burst_cnt     <= '0;
    end else begin
      strobe <= 1'b0;
      if ((state == S_GRANT || state == S_WRITE || state == S_RELEASE) && !enable) begin
        // Abort: the partially filled buffer is committed by dropping activate
        activate <= '0;
        busy     <= 1'b0;
        finished <= 1'b0;
        state    <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (enable && !finished) begin
              mode_q        <= mode;
              pat           <= start_word;
              remaining     <= write_count;
              words_written <= '0;
              if (write_count == '0) begin
                finished <= 1'b1;
                state    <= S_FINISHED;
              end else begin
                busy  <= 1'b1;
                state <= S_GRANT;
              end
            end
          end
          S_GRANT: begin
            if (activate == '0 && ready != '0) begin
              activate  <= lowest_ready;
              burst     <= burst_calc;
              burst_cnt <= '0;
              state     <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (burst_cnt == burst) begin
              // A zero-size buffer still sees activate for one cycle, then a retry
              activate <= '0;
              state    <= S_RELEASE;
            end else begin
              strobe        <= 1'b1;
              fifo_data     <= pat;
              pat           <= next_word;
              burst_cnt     <= burst_cnt + COUNT_WIDTH'(1);
              remaining     <= remaining - COUNT_WIDTH'(1);
              words_written <= words_written + COUNT_WIDTH'(1);
            end
          end
          S_RELEASE: begin
            if (remaining == '0) begin
              busy     <= 1'b0;
              finished <= 1'b1;
              state    <= S_FINISHED;
            end else begin
              state <= S_GRANT;
            end
          end
          S_FINISHED: begin
            if (!enable) begin
              finished <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
